// File: rtl/membus_arbiter_if.sv
// Membus request/response bundle shared by fetch, memunit and memory side.
// Master drives the request payload; slave answers with ready/rvalid/rdata.
interface membus_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) ();
  logic                    valid;
  logic                    ready;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    wen;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wmask;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (
    output valid, addr, wen, wdata, wmask,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, addr, wen, wdata, wmask,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/membus_arbiter.sv
// Shares one Membus port between ibus (fetch) and dbus (memunit), 1 outstanding.
// Define MEMBUS_ARB_RR_EN for round-robin ties; default is fixed dbus priority.
module membus_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic     clk,
  input  logic     rst,
  membus_if.slave  ibus,
  membus_if.slave  dbus,
  membus_if.master mbus,
  output logic     busy
);

  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LOCK      = 2'd1;
  localparam logic [1:0] WAIT_RESP = 2'd2;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  logic [1:0] state;
  logic [1:0] owner;
  logic       last_grant;
  logic       last_grant_nxt;

  logic pick_d;
  logic sel_d;
  logic go;
  logic sel_valid;

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_wen;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [MASK_WIDTH-1:0] sel_wmask;

`ifdef MEMBUS_ARB_RR_EN
  assign pick_d = dbus.valid &
                  (~ibus.valid | (last_grant == GRANT_I));
`else
  assign pick_d = dbus.valid;
`endif

  // Once granted, the owner keeps the port until memory accepts.
  always_comb begin
    sel_d = pick_d;
    unique case (1'b1)
      (state == LOCK): sel_d = (owner == OWN_D);
      default:         sel_d = pick_d;
    endcase
  end

  assign sel_valid = sel_d ? dbus.valid : ibus.valid;
  assign sel_addr  = sel_d ? dbus.addr  : ibus.addr;
  assign sel_wen   = sel_d ? dbus.wen   : ibus.wen;
  assign sel_wdata = sel_d ? dbus.wdata : ibus.wdata;
  assign sel_wmask = sel_d ? dbus.wmask : ibus.wmask;

  assign go = rst & ((state == IDLE) | (state == LOCK));

  assign mbus.valid = go & sel_valid;
  assign mbus.addr  = sel_addr;
  assign mbus.wen   = sel_wen;
  assign mbus.wdata = sel_wdata;
  assign mbus.wmask = sel_wmask;

  assign ibus.ready = mbus.valid & ~sel_d & mbus.ready;
  assign dbus.ready = mbus.valid &  sel_d & mbus.ready;

  // Responses outside WAIT_RESP are dropped on the floor.
  assign ibus.rvalid = (state == WAIT_RESP) &
                       (owner == OWN_I) & mbus.rvalid;
  assign dbus.rvalid = (state == WAIT_RESP) &
                       (owner == OWN_D) & mbus.rvalid;

  assign ibus.rdata = mbus.rdata;
  assign dbus.rdata = mbus.rdata;

  assign busy = (state != IDLE);

  always_comb begin
    last_grant_nxt = last_grant;
    if ((state == WAIT_RESP) && mbus.rvalid) begin
      last_grant_nxt = (owner == OWN_D) ? GRANT_D : GRANT_I;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= OWN_NONE;
      last_grant <= GRANT_I;
    end else begin
      last_grant <= last_grant_nxt;
      unique case (1'b1)
        (state == IDLE): begin
          if (mbus.valid) begin
            owner <= sel_d ? OWN_D : OWN_I;
            state <= mbus.ready ? WAIT_RESP : LOCK;
          end
        end
        (state == LOCK): begin
          if (mbus.ready) state <= WAIT_RESP;
        end
        (state == WAIT_RESP): begin
          if (mbus.rvalid) begin
            state <= IDLE;
            owner <= OWN_NONE;
          end
        end
        default: begin
          state <= IDLE;
          owner <= OWN_NONE;
        end
      endcase
    end
  end

endmodule
